// File: rtl/tone_gen.sv
// Square-wave tone generator: one output period lasts exactly cur_div clocks,
// split into ceil(div/2) high cycles and floor(div/2) low cycles.
module tone_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] div,
  input  logic        en,
  input  logic        restart,
  output logic        tone,
  output logic        period_tick,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t      state, state_n;
  logic [15:0] cur_div, cur_div_n;
  logic [15:0] cnt, cnt_n;

  logic        div_ok;
  logic [15:0] start_cnt;
  logic [15:0] lo_cnt;

  assign div_ok    = (div >= 16'd2);
  assign start_cnt = div - (div >> 1) - 16'd1;
  assign lo_cnt    = (cur_div >> 1) - 16'd1;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cur_div_n = cur_div;
    case (state)
      IDLE: begin
        if (en && div_ok) begin
          state_n   = HIGH;
          cur_div_n = div;
          cnt_n     = start_cnt;
        end
      end
      HIGH, LOW: begin
        if (!en) begin
          state_n = IDLE;
        end else if (restart || (state == LOW && cnt == '0)) begin
          // restart and period end share the same relaunch path
          if (div_ok) begin
            state_n   = HIGH;
            cur_div_n = div;
            cnt_n     = start_cnt;
          end else begin
            state_n = IDLE;
          end
        end else if (cnt != '0) begin
          cnt_n = cnt - 16'd1;
        end else begin
          state_n = LOW;
          cnt_n   = lo_cnt;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe; the tick marks the final LOW cycle itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur_div     <= '0;
      cnt         <= '0;
      tone        <= 1'b0;
      busy        <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      state       <= state_n;
      cur_div     <= cur_div_n;
      cnt         <= cnt_n;
      tone        <= (state_n == HIGH);
      busy        <= (state_n != IDLE);
      period_tick <= (state_n == LOW) && (cnt_n == '0);
    end
  end

endmodule
